// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: 4x4 keypad scanner with debounce and valid/ack key delivery.
// Ports:
//   clk       - system clock, rising edge
//   reset     - active-low asynchronous reset
//   enable    - scan enable; freezes divider, column rotation and sampling when low
//   row[3:0]  - active-high row sense lines for the strobed column
//   col[3:0]  - one-hot column strobe
//   key_code  - accepted key {col_idx, row_idx}
//   key_valid - key_code available
//   key_ack   - consumer accepts key (transfer when key_valid && key_ack)
//   busy      - high whenever the controller is not scanning
module keypad_scan_ctrl #(
    parameter int unsigned SCAN_DIV = 4,
    parameter int unsigned DEBOUNCE = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ack,
    output logic       busy
);

    localparam int unsigned DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        SCAN    = 2'd0,
        CONFIRM = 2'd1,
        HOLD    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t             state, state_nxt;
    logic [DIV_W-1:0]   div, div_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [3:0]         cand, cand_nxt;
    logic [3:0]         col_nxt, code_nxt;
    logic               valid_nxt;

    logic               sample;
    logic [1:0]         col_idx, row_idx;
    logic [3:0]         col_rot;
    logic [CNT_W-1:0]   cnt_inc;
    logic               cnt_done;

    // Sample point: last enabled cycle of the column dwell.
    assign sample   = enable && (div == DIV_W'(SCAN_DIV - 1));
    assign col_rot  = {col[2:0], col[3]};
    assign cnt_inc  = cnt + CNT_W'(1);
    assign cnt_done = (cnt_inc == CNT_W'(DEBOUNCE));

    // One-hot column to index.
    always_comb begin
        col_idx = 2'd0;
        case (col)
            4'b0010: col_idx = 2'd1;
            4'b0100: col_idx = 2'd2;
            4'b1000: col_idx = 2'd3;
            default: col_idx = 2'd0;
        endcase
    end

    // Lowest set row wins when several keys in one column are closed.
    always_comb begin
        row_idx = 2'd0;
        if (row[0])      row_idx = 2'd0;
        else if (row[1]) row_idx = 2'd1;
        else if (row[2]) row_idx = 2'd2;
        else if (row[3]) row_idx = 2'd3;
    end

    // Divider: held at 0 in HOLD so RELEASE starts on a fresh dwell.
    always_comb begin
        div_nxt = div;
        if (state == HOLD)
            div_nxt = '0;
        else if (enable)
            div_nxt = sample ? '0 : div + DIV_W'(1);
    end

    // Next-state and output logic.
    always_comb begin
        state_nxt = state;
        col_nxt   = col;
        cnt_nxt   = cnt;
        cand_nxt  = cand;
        code_nxt  = key_code;
        valid_nxt = key_valid;
        case (state)
            SCAN: begin
                if (sample) begin
                    if (row == 4'd0) begin
                        col_nxt = col_rot;
                    end else begin
                        cand_nxt = {col_idx, row_idx};
                        cnt_nxt  = CNT_W'(1);
                        if (DEBOUNCE == 1) begin
                            code_nxt  = {col_idx, row_idx};
                            valid_nxt = 1'b1;
                            state_nxt = HOLD;
                        end else begin
                            state_nxt = CONFIRM;
                        end
                    end
                end
            end
            CONFIRM: begin
                if (sample) begin
                    if ((row != 4'd0) && ({col_idx, row_idx} == cand)) begin
                        cnt_nxt = cnt_inc;
                        if (cnt_done) begin
                            code_nxt  = cand;
                            valid_nxt = 1'b1;
                            state_nxt = HOLD;
                        end
                    end else begin
                        cnt_nxt   = '0;
                        col_nxt   = col_rot;
                        state_nxt = SCAN;
                    end
                end
            end
            HOLD: begin
                // Row ignored here; only the handshake moves us on.
                if (key_valid && key_ack) begin
                    valid_nxt = 1'b0;
                    cnt_nxt   = '0;
                    state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                if (sample) begin
                    if (row == 4'd0) begin
                        if (cnt_done) begin
                            cnt_nxt   = '0;
                            col_nxt   = col_rot;
                            state_nxt = SCAN;
                        end else begin
                            cnt_nxt = cnt_inc;
                        end
                    end else begin
                        cnt_nxt = '0;
                    end
                end
            end
            default: state_nxt = SCAN;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= SCAN;
            div       <= '0;
            cnt       <= '0;
            cand      <= 4'h0;
            col       <= 4'b0001;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            div       <= div_nxt;
            cnt       <= cnt_nxt;
            cand      <= cand_nxt;
            col       <= col_nxt;
            key_code  <= code_nxt;
            key_valid <= valid_nxt;
            busy      <= (state_nxt != SCAN);
        end
    end

endmodule

// File: doc/keypad_scan_ctrl.md
# keypad_scan_ctrl

Scan controller for the calculator's 4x4 keypad. Drives a one-hot column strobe that rotates like a ring counter, samples the four row lines, debounces a pressed key, and delivers a 4-bit key code over a valid/ack handshake to the calculator front end. It holds the scan on the pressed column until the key is consumed and released, so each physical press produces exactly one code.

## Interface
- SCAN_DIV, default 4: enabled clock cycles per column dwell. Legal values are ≥ 2.
- DEBOUNCE, default 3: consecutive matching samples required to accept a press or a release. Legal values are 1..15.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  reset. Active-low, asynchronous assert, synchronous release.
- enable  in  1  scan enable. When low, the divider, column rotation and all sampling freeze.
- row  in  4  row sense lines, active-high. row[i]=1 means a key at (active column, row i) is closed.
- col  out  4  one-hot column strobe.
- key_code  out  4  accepted key, encoded as {col_idx[1:0], row_idx[1:0]}.
- key_valid  out  1  key_code is available.
- key_ack  in  1  consumer accepts the key. A transfer happens on the edge where key_valid and key_ack are both 1.
- busy  out  1  high in any state other than SCAN.

## Operation
- Reset values:
  - col = 4'b0001
  - key_code = 4'h0
  - key_valid = 0
  - busy = 0
  - state = SCAN
  - divider = 0
  - debounce counter = 0
- Divider and sampling:
  - The divider counts enabled cycles from 0 to SCAN_DIV-1.
  - A sample is taken on the edge where divider == SCAN_DIV-1; the divider then wraps to 0.
- Row decode:
  - row_idx is the lowest set bit of row.
  - row == 0 means "no key".
- State machine:
  - SCAN
    - col rotates 0001→0010→0100→1000→0001 on each sample edge whose row == 0.
    - A sample with row != 0 captures cand = {col_idx, row_idx} and sets cnt = 1. col does not advance. The state goes to CONFIRM, or straight to HOLD if DEBOUNCE == 1.
  - CONFIRM
    - col is frozen.
    - A sample whose code equals cand increments cnt. When cnt reaches DEBOUNCE: key_code ← cand, key_valid ← 1, state goes to HOLD.
    - A sample whose code differs (including "no key") clears cnt, advances col one position and returns to SCAN.
  - HOLD
    - col is frozen and the divider is held at 0.
    - key_valid stays 1 and key_code stays stable until the transfer edge.
    - On the transfer edge: key_valid ← 0, state goes to RELEASE, cnt ← 0.
    - The row value is ignored in HOLD, so a release or re-press before ack has no effect.
  - RELEASE
    - col is frozen.
    - A sample with row == 0 increments cnt. When cnt reaches DEBOUNCE: state goes to SCAN, col advances one position, cnt ← 0.
    - A sample with row != 0 clears cnt.
- key_ack while key_valid == 0 is ignored.
- enable = 0:
  - The divider, col and cnt hold in every state.
  - The HOLD handshake still completes. HOLD→RELEASE proceeds, and RELEASE sampling resumes when enable returns.
- Reset asserted mid-operation returns all outputs to their reset values immediately. A pending key is discarded.

## Timing
- First sample is on the SCAN_DIV-th enabled edge after reset release.
- Press latency: key_valid rises after the edge of the DEBOUNCE-th matching sample. This is DEBOUNCE·SCAN_DIV enabled cycles after the column's dwell begins; with defaults, 12 cycles.
- key_valid drops after the transfer edge, so it has a 1-cycle fall latency.
- Back-to-back keys: the minimum gap from transfer to the next possible key_valid is (DEBOUNCE + DEBOUNCE)·SCAN_DIV enabled cycles.
- Outputs are registered; there are no combinational paths from row or key_ack to any output.

## Test plan
- Reset mid-CONFIRM:
  - Stimulus: pull reset low asynchronously, then release it.
  - Required response: col=0001, key_valid=0, key_code=0, busy=0 before the next edge; the first sample occurs 4 cycles after release.
- Single press at column 2, row 1, held, with row driven as pressed&col:
  - key_code=4'h9 and key_valid=1 after 3 matching samples (12 cycles from the start of the column-2 dwell).
  - Ack on the next cycle drops key_valid 1 cycle later.
  - Releasing the key for 3 samples returns the block to SCAN with col=1000.
- Bounce:
  - Stimulus: row active for one sample only.
  - Required response: no key_valid; col advances and scanning continues with busy returning to 0.
- Two keys in column 1, rows 0 and 3 pressed:
  - Required response: key_code=4'h4 (lowest row wins).
- Ack delayed 20 cycles:
  - key_valid stays 1 and key_code stays stable.
  - Release and re-press during HOLD produce no second key.
  - Toggling enable low during HOLD does not block the transfer.
- Release glitch:
  - Stimulus: in RELEASE, row goes 0, 0, 1, 0, 0, 0 across six samples.
  - Required response: cnt restarts after the glitch; SCAN resumes only after the final three zero samples.
